inst_fetch_decoder: RTL and testbench
=====================================

// Module: inst_fetch_decoder
// PURPOSE
//  Instruction buffer + decoder directly upstream of the fill/BLA datapath. Host pushes packed
//  80-bit instruction words into an internal FIFO; main controller pops via read_en. Popped word
//  is decoded into registered fields (coordinates, vertice_num, fill_type, texture/colour, layer)
//  held stable until next pop. Drives fifo_empty to main controller.
// PARAMETERS
//  INST_W      80   instruction word width (fixed layout below; must be 80)
//  FIFO_DEPTH  8    entries, power of two, >=2
//  CNT_W       4    occupancy width = $clog2(FIFO_DEPTH)+1
// PORTS
//  clk          in   1    single clock, rising edge
//  rst          in   1    synchronous, active-high reset
//  push         in   1    host write strobe
//  inst_in      in   80   packed instruction (see layout)
//  full         out  1    FIFO full (combinational from count)
//  read_en      in   1    pop request from main controller
//  fifo_empty   out  1    FIFO empty (combinational from count)
//  inst_valid   out  1    1-cycle pulse: decoded fields updated this cycle
//  inst_op      out  2    opcode of current instruction
//  vertice_num  out  1    BLA vertex select
//  coordinates  out  48   {x0,y0,x1,y1} 12b each
//  fill_type    out  1    0=solid colour, 1=texture
//  texture_code out  2    texture select
//  color_code   out  24   RGB888
//  layer_num    out  1    target layer
//  count        out  4    current occupancy 0..FIFO_DEPTH
//  overflow     out  1    sticky: push dropped while full
//  underflow    out  1    sticky: read_en while empty
// BEHAVIOUR
//  Layout: [79:78] op (00 CONFIG,01 LINE,10 FILL,11 ALPHA), [77] vertice_num, [76] fill_type,
//   [75:74] texture_code, [73] layer_num, [72:49] color_code, [48] reserved(ignored), [47:0] coords.
//  Reset (sync, rst=1 at edge): wr/rd ptr=0, count=0, all decoded outputs=0, inst_valid=0,
//   overflow=0, underflow=0. fifo_empty=1, full=0 after reset. Mid-operation reset discards
//   all stored entries; push/read_en in same cycle as rst are ignored.
//  Push accepted iff push && (!full || pop_ok); written at wr_ptr, wr_ptr wraps mod FIFO_DEPTH.
//  pop_ok = read_en && !fifo_empty. On pop_ok: head entry decoded into output regs at that edge;
//   inst_valid=1 the following cycle only (latency 1 clk read_en->fields). rd_ptr wraps.
//  Outputs hold last popped instruction until next pop_ok; never change otherwise.
//  Simultaneous push+pop: count unchanged; allowed when full (pop frees slot same cycle).
//   When empty, push+read_en: pop rejected (no bypass), push accepted, underflow set.
//  push && full && !pop_ok: word dropped, overflow<=1 (sticky until rst).
//  read_en && fifo_empty: no state change except underflow<=1 (sticky until rst).
//  count = accepted pushes - accepted pops; never exceeds FIFO_DEPTH.
//  FSM in decoder: IDLE -> (pop_ok) LOAD -> (next clk) IDLE; LOAD asserts inst_valid.
//   pop_ok while in LOAD allowed (back-to-back pops -> inst_valid high consecutive cycles).
// STRUCTURE
//  Package gpu_inst_pkg: op_t enum {OP_CONFIG,OP_LINE,OP_FILL,OP_ALPHA}, INST_W, field
//   MSB/LSB localparams, inst_fields_t packed struct matching layout.
//  Sub-module inst_fifo (generic sync FIFO: data/ptrs/count/full/empty); decode+FSM+sticky
//   flags in top.
// TESTING
//  Reset then 1 push op=01, coords=48'h00A_014_0C8_064 -> fifo_empty 1->0; read_en -> next clk
//   inst_valid=1, inst_op=01, coordinates match, fifo_empty=1.
//  Push 8 words (op=10, color 24'hFF8000..+1) -> full=1,count=8; 9th push -> dropped, overflow=1;
//   8 pops return the 8 colours in order, 9th read_en -> underflow=1, outputs unchanged.
//  Full FIFO, push+read_en same cycle -> count stays 8, overflow stays 0, new word popped last.
//  Empty FIFO, push+read_en same cycle -> count=1, inst_valid stays 0, underflow=1.
//  Fill to 5, assert rst one cycle with push=1 -> count=0, fifo_empty=1, all fields 0, flags 0.
//  Wrap: 20 interleaved push/pop with random fields incl. [48]=1 -> scoreboard order/fields exact.

Source files
------------

// File: rtl/gpu_inst_pkg.sv
// Shared types for the instruction buffer: opcode enum, field positions and
// a packed view of the 80-bit instruction word.
package gpu_inst_pkg;

   localparam int INST_W = 80;

   localparam int OP_MSB      = 79;
   localparam int OP_LSB      = 78;
   localparam int VERT_BIT    = 77;
   localparam int FILL_BIT    = 76;
   localparam int TEX_MSB     = 75;
   localparam int TEX_LSB     = 74;
   localparam int LAYER_BIT   = 73;
   localparam int COLOR_MSB   = 72;
   localparam int COLOR_LSB   = 49;
   localparam int RSV_BIT     = 48;
   localparam int COORD_MSB   = 47;
   localparam int COORD_LSB   = 0;

   typedef enum logic [1:0] {
      OP_CONFIG = 2'b00,
      OP_LINE   = 2'b01,
      OP_FILL   = 2'b10,
      OP_ALPHA  = 2'b11
   } op_t;

   // Field order matches the bit layout from MSB down to LSB.
   typedef struct packed {
      op_t         op;
      logic        vertice_num;
      logic        fill_type;
      logic [1:0]  texture_code;
      logic        layer_num;
      logic [23:0] color_code;
      logic        reserved;
      logic [47:0] coordinates;
   } inst_fields_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_LOAD = 1'b1
   } dec_state_t;

endpackage

// File: rtl/inst_fifo.sv
// Generic synchronous FIFO. Push is accepted when not full, or when a pop
// frees a slot in the same cycle. Pops on empty are rejected (no bypass).
module inst_fifo #(
   parameter int DATA_W     = 80,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic              push_ok,
   output logic              pop_ok,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign pop_ok  = rd_en && !empty;
   assign push_ok = wr_en && (!full || pop_ok);
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (depth is a power of two).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array is data only; stale contents are unreachable once pointers reset.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/inst_fetch_decoder.sv
// Instruction buffer plus decoder: buffers host instruction words and, on each
// accepted pop, latches the head word's fields into stable output registers.
module inst_fetch_decoder
   import gpu_inst_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [INST_W-1:0] inst_in,
   output logic              full,
   input  logic              read_en,
   output logic              fifo_empty,
   output logic              inst_valid,
   output logic [1:0]        inst_op,
   output logic              vertice_num,
   output logic [47:0]       coordinates,
   output logic              fill_type,
   output logic [1:0]        texture_code,
   output logic [23:0]       color_code,
   output logic              layer_num,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);

   logic [INST_W-1:0] head_word;
   inst_fields_t      head;
   logic              push_ok;
   logic              pop_ok;
   logic              unused_push_ok;
   logic              unused_reserved;
   dec_state_t        state;
   dec_state_t        state_next;

   inst_fifo #(
      .DATA_W     (INST_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (inst_in),
      .rd_en   (read_en),
      .rd_data (head_word),
      .full    (full),
      .empty   (fifo_empty),
      .push_ok (push_ok),
      .pop_ok  (pop_ok),
      .count   (count)
   );

   assign head            = inst_fields_t'(head_word);
   // The reserved bit carries no meaning and push acceptance is tracked inside the FIFO.
   assign unused_reserved = head.reserved;
   assign unused_push_ok  = push_ok;

   // Decoder state register: LOAD marks the cycle after a pop.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next state: every accepted pop (including back-to-back) lands in LOAD.
   always_comb begin
      state_next = S_IDLE;
      if (pop_ok) state_next = S_LOAD;
   end

   // Output decode: inst_valid pulses while in LOAD.
   always_comb begin
      inst_valid = (state == S_LOAD);
   end

   // Decoded field registers: updated only on an accepted pop, otherwise held.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_op      <= '0;
         vertice_num  <= 1'b0;
         fill_type    <= 1'b0;
         texture_code <= '0;
         layer_num    <= 1'b0;
         color_code   <= '0;
         coordinates  <= '0;
      end else if (pop_ok) begin
         inst_op      <= head.op;
         vertice_num  <= head.vertice_num;
         fill_type    <= head.fill_type;
         texture_code <= head.texture_code;
         layer_num    <= head.layer_num;
         color_code   <= head.color_code;
         coordinates  <= head.coordinates;
      end
   end

   // Sticky error flags: dropped push when full, read attempt when empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push && full && !pop_ok) overflow  <= 1'b1;
         if (read_en && fifo_empty)   underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_fetch_decoder.sv
// Scoreboard bench for inst_fetch_decoder: accepted pushes are queued, and
// each accepted pop is compared against the queue head one cycle later.
module tb_inst_fetch_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        push;
   logic [79:0] inst_in;
   logic        full;
   logic        read_en;
   logic        fifo_empty;
   logic        inst_valid;
   logic [1:0]  inst_op;
   logic        vertice_num;
   logic [47:0] coordinates;
   logic        fill_type;
   logic [1:0]  texture_code;
   logic [23:0] color_code;
   logic        layer_num;
   logic [3:0]  count;
   logic        overflow;
   logic        underflow;

   int total = 0;
   int bad   = 0;
   logic [79:0] sb[$];

   localparam logic [79:0] RSV_MASK = ~(80'd1 << 48);

   always #5 clk = ~clk;

   inst_fetch_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .push         (push),
      .inst_in      (inst_in),
      .full         (full),
      .read_en      (read_en),
      .fifo_empty   (fifo_empty),
      .inst_valid   (inst_valid),
      .inst_op      (inst_op),
      .vertice_num  (vertice_num),
      .coordinates  (coordinates),
      .fill_type    (fill_type),
      .texture_code (texture_code),
      .color_code   (color_code),
      .layer_num    (layer_num),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Reassemble the decoded outputs into layout order (reserved bit reads as 0).
   function automatic logic [79:0] obs();
      return {inst_op, vertice_num, fill_type, texture_code, layer_num,
              color_code, 1'b0, coordinates};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; push = 1'b0; read_en = 1'b0;
      step();
      rst = 1'b0;
      sb.delete();
   endtask

   // Push one word, updating the scoreboard with the expected acceptance rule.
   task automatic push_word(input logic [79:0] w);
      push = 1'b1; inst_in = w;
      if (sb.size() < 8) sb.push_back(w);
      step();
      push = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; push = 1'b1; read_en = 1'b1; inst_in = '1;
      step(); step();
      rst = 1'b0; push = 1'b0; read_en = 1'b0;
      sb.delete();
      total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", fifo_empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
      total++; if ({overflow, underflow} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {overflow, underflow}); end
      total++; if (obs() !== 80'd0) begin bad++; $display("FAIL reset_fields got=%h want=0", obs()); end
   endtask

   task automatic test_single();
      logic [79:0] w;
      do_reset();
      w = {2'b01, 1'b1, 1'b0, 2'b10, 1'b1, 24'h123456, 1'b0, 48'h00A_014_0C8_064};
      push_word(w);
      total++; if (fifo_empty !== 1'b0) begin bad++; $display("FAIL single_nonempty got=%b want=0", fifo_empty); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL single_novalid got=%b want=0", inst_valid); end
      read_en = 1'b1;
      step();
      read_en = 1'b0;
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", inst_valid); end
      total++; if (inst_op !== 2'b01) begin bad++; $display("FAIL single_op got=%b want=01", inst_op); end
      total++; if (coordinates !== 48'h00A_014_0C8_064) begin bad++; $display("FAIL single_coords got=%h want=00a0140c8064", coordinates); end
      total++; if (obs() !== w) begin bad++; $display("FAIL single_fields got=%h want=%h", obs(), w); end
      total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL single_empty_after got=%b want=1", fifo_empty); end
      step();
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b want=0", inst_valid); end
      total++; if (obs() !== w) begin bad++; $display("FAIL single_hold got=%h want=%h", obs(), w); end
   endtask

   task automatic test_full_overflow();
      logic [79:0] exp;
      logic [79:0] last;
      do_reset();
      for (int i = 0; i < 8; i++)
         push_word({2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 24'hFF8000 + 24'(i), 1'b0, 48'(i)});
      total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b want=1", full); end
      total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d want=8", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_noovf got=%b want=0", overflow); end
      push_word({2'b11, 78'h3FFF_FFFF_FFFF_FFFF_FFF});
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
      total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", count); end
      for (int i = 0; i < 8; i++) begin
         exp = sb.pop_front();
         read_en = 1'b1;
         step();
         read_en = 1'b0;
         total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got=%b want=1", i, inst_valid); end
         total++; if (color_code !== 24'hFF8000 + 24'(i)) begin bad++; $display("FAIL drain_color[%0d] got=%h want=%h", i, color_code, 24'hFF8000 + 24'(i)); end
         total++; if (obs() !== (exp & RSV_MASK)) begin bad++; $display("FAIL drain_fields[%0d] got=%h want=%h", i, obs(), exp & RSV_MASK); end
      end
      last = obs();
      read_en = 1'b1;
      step();
      read_en = 1'b0;
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b want=1", underflow); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL udf_novalid got=%b want=0", inst_valid); end
      total++; if (obs() !== last) begin bad++; $display("FAIL udf_hold got=%h want=%h", obs(), last); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [79:0] exp;
      logic [79:0] nw;
      do_reset();
      for (int i = 0; i < 8; i++)
         push_word({2'b00, 6'h2A, 24'(i * 3), 1'b0, 48'hABC000 + 48'(i)});
      nw = {2'b01, 1'b1, 1'b1, 2'b11, 1'b1, 24'hC0FFEE, 1'b0, 48'hFED_CBA_987_654};
      exp = sb.pop_front();
      sb.push_back(nw);
      push = 1'b1; read_en = 1'b1; inst_in = nw;
      step();
      push = 1'b0; read_en = 1'b0;
      total++; if (count !== 4'd8) begin bad++; $display("FAIL fpp_count got=%0d want=8", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_noovf got=%b want=0", overflow); end
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL fpp_valid got=%b want=1", inst_valid); end
      total++; if (obs() !== exp) begin bad++; $display("FAIL fpp_head got=%h want=%h", obs(), exp); end
      // Back-to-back pops: inst_valid stays high each cycle.
      read_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = sb.pop_front();
         step();
         total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", i, inst_valid); end
         total++; if (obs() !== exp) begin bad++; $display("FAIL b2b_fields[%0d] got=%h want=%h", i, obs(), exp); end
      end
      read_en = 1'b0;
      total++; if (obs() !== nw) begin bad++; $display("FAIL fpp_last got=%h want=%h", obs(), nw); end
      total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL fpp_empty got=%b want=1", fifo_empty); end
   endtask

   task automatic test_empty_push_pop();
      logic [79:0] w;
      do_reset();
      w = {2'b10, 1'b1, 1'b1, 2'b01, 1'b0, 24'h00FF00, 1'b0, 48'h111_222_333_444};
      push = 1'b1; read_en = 1'b1; inst_in = w;
      sb.push_back(w);
      step();
      push = 1'b0; read_en = 1'b0;
      total++; if (count !== 4'd1) begin bad++; $display("FAIL epp_count got=%0d want=1", count); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL epp_novalid got=%b want=0", inst_valid); end
      total++; if (underflow !== 1'b1) begin bad++; $display("FAIL epp_udf got=%b want=1", underflow); end
      total++; if (obs() !== 80'd0) begin bad++; $display("FAIL epp_nobypass got=%h want=0", obs()); end
      read_en = 1'b1;
      step();
      read_en = 1'b0;
      void'(sb.pop_front());
      total++; if (obs() !== w) begin bad++; $display("FAIL epp_pop got=%h want=%h", obs(), w); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++)
         push_word({2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 24'hABCDEF, 1'b0, 48'(i + 1)});
      read_en = 1'b1;
      step();
      read_en = 1'b0;
      rst = 1'b1; push = 1'b1; read_en = 1'b1; inst_in = '1;
      step();
      rst = 1'b0; push = 1'b0; read_en = 1'b0;
      sb.delete();
      total++; if (count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
      total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b want=1", fifo_empty); end
      total++; if (obs() !== 80'd0) begin bad++; $display("FAIL mid_fields got=%h want=0", obs()); end
      total++; if ({overflow, underflow, inst_valid} !== 3'b000) begin bad++; $display("FAIL mid_flags got=%b want=000", {overflow, underflow, inst_valid}); end
   endtask

   task automatic test_wrap();
      logic [95:0] r;
      logic [79:0] w;
      logic [79:0] exp;
      logic        p;
      logic        rd;
      logic        pop_exp;
      int          pushes;
      do_reset();
      pushes = 0;
      for (int i = 0; i < 60 && pushes < 20; i++) begin
         r = {$urandom(), $urandom(), $urandom()};
         w = r[79:0];
         w[48] = 1'b1;
         p  = ($urandom_range(0, 3) != 0);
         rd = ($urandom_range(0, 2) != 0);
         pop_exp = rd && (sb.size() > 0);
         exp = '0;
         if (pop_exp) exp = sb.pop_front();
         if (p && (sb.size() < 8)) begin sb.push_back(w); pushes++; end
         push = p; read_en = rd; inst_in = w;
         step();
         push = 1'b0; read_en = 1'b0;
         total++; if (inst_valid !== pop_exp) begin bad++; $display("FAIL wrap_valid[%0d] got=%b want=%b", i, inst_valid, pop_exp); end
         if (pop_exp) begin
            total++; if (obs() !== (exp & RSV_MASK)) begin bad++; $display("FAIL wrap_fields[%0d] got=%h want=%h", i, obs(), exp & RSV_MASK); end
         end
         total++; if (count !== 4'(sb.size())) begin bad++; $display("FAIL wrap_count[%0d] got=%0d want=%0d", i, count, sb.size()); end
      end
      read_en = 1'b1;
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         step();
         total++; if (obs() !== (exp & RSV_MASK)) begin bad++; $display("FAIL wrap_drain got=%h want=%h", obs(), exp & RSV_MASK); end
      end
      read_en = 1'b0;
      total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", fifo_empty); end
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; read_en = 1'b0; inst_in = '0;
      test_reset();
      test_single();
      test_full_overflow();
      test_full_push_pop();
      test_empty_push_pop();
      test_reset_mid();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
